// File: rtl/sum_serializer.sv
// UART-style serializer: start bit, 8 data bits LSB first, even parity, stop bit.
// A one-deep holding buffer lets the next word follow the current frame with no idle gap.
module sum_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] data_q, data_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       tx_q, tx_d;

    logic accept;
    logic last_tick;

    assign in_ready  = ~buf_full_q;
    assign accept    = in_valid & in_ready & ena;
    assign last_tick = (cnt_q == LastCnt);
    assign tx        = tx_q;
    assign busy      = (state_q != StIdle) | buf_full_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        tx_d       = tx_q;

        if (ena) begin
            if (state_q != StIdle) begin
                cnt_d = last_tick ? 8'd0 : cnt_q + 8'd1;
            end

            // tx_d is the value for the state being entered, so tx stays registered.
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        data_d  = in_data;
                        cnt_d   = 8'd0;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end
                end
                StStart: begin
                    if (last_tick) begin
                        bit_d   = 3'd0;
                        state_d = StData;
                        tx_d    = data_q[0];
                    end
                end
                StData: begin
                    if (last_tick) begin
                        if (bit_q == 3'd7) begin
                            state_d = StParity;
                            tx_d    = ^data_q;
                        end else begin
                            bit_d = bit_q + 3'd1;
                            tx_d  = data_q[bit_q + 3'd1];
                        end
                    end
                end
                StParity: begin
                    if (last_tick) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end
                end
                StStop: begin
                    if (last_tick) begin
                        if (buf_full_q) begin
                            data_d     = buf_q;
                            buf_full_d = 1'b0;
                            state_d    = StStart;
                            tx_d       = 1'b0;
                        end else if (accept) begin
                            data_d  = in_data;
                            state_d = StStart;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = StIdle;
                            tx_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            endcase

            // A word arriving exactly at the end of STOP goes straight to the shifter instead.
            if (accept && (state_q != StIdle) && !((state_q == StStop) && last_tick)) begin
                buf_d      = in_data;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            data_q     <= 8'd0;
            buf_q      <= 8'd0;
            buf_full_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: doc/sum_serializer.md
SUM_SERIALIZER -- requirements
Module: sum_serializer

Downstream consumer of the 8-bit sum output: frames each word as a UART-style serial stream with a one-deep holding buffer.

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ena, input, 1 bit: advance enable; low freezes all state.
REQ-005 SHALL have port in_data, input, 8 bits: word to transmit.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress or a word is buffered.

Function
REQ-010 SHALL accept a word on a rising edge where in_valid=1, in_ready=1 and ena=1; in_data is sampled at that edge.
REQ-011 SHALL drive in_ready = ~buf_full, combinationally, independent of in_valid.
REQ-012 SHALL, when accepting in IDLE with the buffer empty, load the word straight into the shift register and enter START.
REQ-013 SHALL, when accepting in any other state, store the word in the holding buffer and set buf_full.
REQ-014 SHALL keep in_valid=1 with in_ready=0 as a stall: no data lost, no state change.
REQ-015 SHALL implement the FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; every non-IDLE state lasts CLKS_PER_BIT cycles, except DATA, which lasts 8*CLKS_PER_BIT.
REQ-016 SHALL drive tx: IDLE=1, START=0, DATA=data bits LSB first, PARITY=XOR of the 8 data bits (even parity), STOP=1.
REQ-017 SHALL register tx, so tx changes only on clock edges.
REQ-018 SHALL make the first START cycle the cycle after the accepting edge; a full frame is 11*CLKS_PER_BIT cycles.
REQ-019 SHALL, at the end of STOP with buf_full=1, move the buffer into the shift register, clear buf_full and enter START on the next cycle, with no idle gap.
REQ-020 SHALL, on a simultaneous end of STOP and acceptance while buf_full=0, transmit the accepted word back-to-back on the same rule as REQ-019.
REQ-021 SHALL drive busy = (state != IDLE) | buf_full.
REQ-022 SHALL, with ena=0, hold the bit counter, the cycle counter, the state, tx and the buffer, and accept nothing; in_ready still reflects buf_full.
REQ-023 SHALL use an 8-bit cycle counter that wraps from CLKS_PER_BIT-1 to 0 and a 3-bit data-bit index.

Reset
REQ-024 SHALL, while rst_n=0, immediately force: state=IDLE, tx=1, buf_full=0, in_ready=1, busy=0, counters=0.
REQ-025 SHALL, on reset mid-frame, abort the frame and discard any buffered word; no partial frame resumes after reset.
REQ-026 SHALL treat rst_n deassertion as synchronous to clk, so the first acceptance is possible on the first edge after release.

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL verify single word: 0xA5 accepted from IDLE -> tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,0,1 (start, b0..b7, parity 0, stop); busy high for 44 cycles, then tx=1.
REQ-028 SHALL verify parity: 0x07 -> parity bit 1; 0x00 -> parity bit 0 with all data bits 0.
REQ-029 SHALL verify back-to-back: 0x12, then 0x34 at cycle 5 -> in_ready=0 from cycle 6 until 0x34 moves to the shift register; second start bit immediately follows the first stop bit (88 cycles busy).
REQ-030 SHALL verify stall: third word 0x56 held valid while buf_full=1 -> not accepted until in_ready rises; all three frames appear in order.
REQ-031 SHALL verify ena freeze: ena=0 for 10 cycles mid DATA -> tx constant, and the frame stretches by exactly 10 cycles.
REQ-032 SHALL verify async reset: rst_n pulsed low mid PARITY with buffer full -> tx=1 and busy=0 without a clock edge; a new word 0xFF then yields a clean 44-cycle frame.
